// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one downstream SRAM-like master port between an
// instruction-fetch requester (i_*) and a data requester (d_*). At most one
// transaction is outstanding. Data wins ties unless fetch has been passed over
// INST_STARVE_LIMIT times in a row.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_req/i_wr/i_size/i_addr/i_wdata  instruction request fields (in)
//   i_addr_ok/i_data_ok/i_rdata       instruction handshakes and read data (out)
//   d_req/d_wr/d_size/d_addr/d_wdata  data request fields (in)
//   d_addr_ok/d_data_ok/d_rdata       data handshakes and read data (out)
//   m_req/m_wr/m_size/m_addr/m_wdata  downstream request (out)
//   m_addr_ok/m_data_ok/m_rdata       downstream handshakes and read data (in)
module sram_like_arbiter #(
  parameter int unsigned INST_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e     state_q, state_d;
  logic       gnt_q, gnt_d;        // 0 = inst, 1 = data
  logic [3:0] skip_cnt_q, skip_cnt_d;

  logic fetch_due;
  logic data_wins;

  // Fetch is forced through once data has been preferred LIMIT times in a row.
  assign fetch_due = (skip_cnt_q == 4'(INST_STARVE_LIMIT));
  assign data_wins = d_req && !(i_req && fetch_due);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    skip_cnt_d = skip_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          state_d = StAddr;
          gnt_d   = data_wins;
          if (data_wins && i_req) begin
            skip_cnt_d = (skip_cnt_q == 4'hf) ? 4'hf : skip_cnt_q + 4'd1;
          end else begin
            skip_cnt_d = 4'd0;
          end
        end
      end
      StAddr: begin
        if (m_addr_ok) state_d = StData;
      end
      StData: begin
        if (m_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      skip_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  logic in_addr;
  logic in_data;

  assign in_addr = (state_q == StAddr);
  assign in_data = (state_q == StData);

  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (in_addr) begin
      m_req   = 1'b1;
      m_wr    = gnt_q ? d_wr    : i_wr;
      m_size  = gnt_q ? d_size  : i_size;
      m_addr  = gnt_q ? d_addr  : i_addr;
      m_wdata = gnt_q ? d_wdata : i_wdata;
    end
  end

  // Handshakes are forwarded only in the phase that expects them.
  assign i_addr_ok = in_addr && m_addr_ok && !gnt_q;
  assign d_addr_ok = in_addr && m_addr_ok &&  gnt_q;
  assign i_data_ok = in_data && m_data_ok && !gnt_q;
  assign d_data_ok = in_data && m_data_ok &&  gnt_q;

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter. Expected transactions are pushed
// onto a scoreboard as requests are raised and popped when the data_ok for the
// transaction is observed.
module tb_sram_like_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  sram_like_arbiter #(.INST_STARVE_LIMIT(Limit)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  // aok/dok are {data, inst} handshake bits seen in the addr_ok / data_ok cycle.
  typedef struct packed {
    logic [1:0]  aok;
    logic [1:0]  dok;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  typedef struct packed {
    txn_t txn;
    int   lat;       // cycles from request to m_req
    bit   timeout;
    int   extra;     // unexpected handshake pulses or m_req outside ADDR
    bit   unstable;  // m_* changed while waiting for m_addr_ok
  } obs_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  txn_t sb[$];

  function automatic txn_t mk(input logic data, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
    txn_t t;
    t.aok   = data ? 2'b10 : 2'b01;
    t.dok   = t.aok;
    t.wr    = wr;
    t.size  = size;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    return t;
  endfunction

  // Downstream model: waits for m_req, stalls m_addr_ok for aw cycles, returns
  // data dw cycles after addr_ok. Records what it saw; callers do the checking.
  task automatic serve(input int aw, input int dw, input logic [31:0] rd, input bit drop,
                       input bit spur, output obs_t o);
    o = '0;
    #1;
    while (!m_req && o.lat < 8) begin
      @(posedge clk); #2;
      o.lat++;
    end
    if (!m_req) begin
      o.timeout = 1'b1;
      return;
    end
    o.txn.wr    = m_wr;
    o.txn.size  = m_size;
    o.txn.addr  = m_addr;
    o.txn.wdata = m_wdata;
    for (int k = 0; k < aw; k++) begin
      if (i_addr_ok | d_addr_ok | i_data_ok | d_data_ok) o.extra++;
      @(posedge clk); #2;
      if ({m_req, m_wr, m_size, m_addr, m_wdata} !==
          {1'b1, o.txn.wr, o.txn.size, o.txn.addr, o.txn.wdata}) o.unstable = 1'b1;
    end
    m_addr_ok = 1'b1;
    #1;
    o.txn.aok = {d_addr_ok, i_addr_ok};
    if (i_data_ok | d_data_ok) o.extra++;
    @(posedge clk); #1;
    m_addr_ok = 1'b0;
    if (drop) begin
      if (o.txn.aok[0]) i_req = 1'b0;
      if (o.txn.aok[1]) d_req = 1'b0;
    end
    #1;
    for (int k = 1; k < dw; k++) begin
      if (spur) m_addr_ok = 1'b1;
      #1;
      if (m_req | i_addr_ok | d_addr_ok | i_data_ok | d_data_ok) o.extra++;
      m_addr_ok = 1'b0;
      @(posedge clk); #2;
    end
    m_data_ok = 1'b1;
    m_rdata   = rd;
    #1;
    o.txn.dok   = {d_data_ok, i_data_ok};
    o.txn.rdata = o.txn.dok[1] ? d_rdata : i_rdata;
    if (i_addr_ok | d_addr_ok | m_req) o.extra++;
    @(posedge clk); #1;
    m_data_ok = 1'b0;
    m_rdata   = $urandom;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_wr = 1'b1; d_wr = 1'b1;
    i_size = 2'd2; d_size = 2'd2; i_addr = 32'h1234; d_addr = 32'h5678;
    i_wdata = 32'hffff_ffff; d_wdata = 32'hffff_ffff;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'ha5a5_5a5a;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if ({m_req, m_wr, m_size, m_addr, m_wdata} !== 68'd0) begin
      n_bad++;
      $display("FAIL reset_mfields: got %h want 0", {m_req, m_wr, m_size, m_addr, m_wdata});
    end
    n_cmp++;
    if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_handshakes: got %b want 0000",
               {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok});
    end
    n_cmp++;
    if ({i_rdata, d_rdata} !== {32'ha5a5_5a5a, 32'ha5a5_5a5a}) begin
      n_bad++;
      $display("FAIL reset_rdata_pass: got %h/%h want a5a55a5a", i_rdata, d_rdata);
    end
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; i_wr = 1'b0; d_wr = 1'b0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    @(posedge clk); #2;
    n_cmp++;
    if (m_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: m_req got %b want 0", m_req);
    end
  endtask

  task automatic test_single_read();
    obs_t o;
    txn_t e;
    i_req = 1'b1; i_wr = 1'b0; i_size = 2'd2; i_addr = 32'hbfc0_0000; i_wdata = 32'd0;
    sb.push_back(mk(1'b0, 1'b0, 2'd2, 32'hbfc0_0000, 32'd0, 32'h3c1d_0010));
    serve(1, 2, 32'h3c1d_0010, 1'b1, 1'b0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.lat !== 1) begin
      n_bad++;
      $display("FAIL single_latency: got %0d want 1", o.lat);
    end
    n_cmp++;
    if (o.txn !== e) begin
      n_bad++;
      $display("FAIL single_txn: got %h want %h", o.txn, e);
    end
    n_cmp++;
    if (o.extra !== 0) begin
      n_bad++;
      $display("FAIL single_extra_pulses: got %0d want 0", o.extra);
    end
  endtask

  task automatic test_data_priority();
    obs_t o;
    txn_t e;
    i_req = 1'b1; i_wr = 1'b0; i_size = 2'd2; i_addr = 32'hbfc0_0004; i_wdata = 32'd0;
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h8000_1000; d_wdata = 32'hdead_beef;
    sb.push_back(mk(1'b1, 1'b1, 2'd2, 32'h8000_1000, 32'hdead_beef, 32'h0));
    sb.push_back(mk(1'b0, 1'b0, 2'd2, 32'hbfc0_0004, 32'd0, 32'h2408_0001));
    serve(1, 1, 32'h0, 1'b1, 1'b0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.txn !== e) begin
      n_bad++;
      $display("FAIL prio_data_first: got %h want %h", o.txn, e);
    end
    serve(1, 1, 32'h2408_0001, 1'b1, 1'b0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.txn !== e) begin
      n_bad++;
      $display("FAIL prio_inst_second: got %h want %h", o.txn, e);
    end
    n_cmp++;
    if (o.lat !== 1) begin
      n_bad++;
      $display("FAIL prio_inst_latency: got %0d want 1", o.lat);
    end
  endtask

  task automatic test_starvation();
    obs_t o;
    txn_t e;
    i_req = 1'b1; i_wr = 1'b0; i_size = 2'd2; i_addr = 32'hbfc0_0100; i_wdata = 32'd0;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd1; d_addr = 32'h8000_2000; d_wdata = 32'h0bad_cafe;
    for (int k = 0; k < 10; k++) begin
      logic is_inst;
      is_inst = (k == int'(Limit)) || (k == 2 * int'(Limit) + 1);
      if (is_inst) sb.push_back(mk(1'b0, 1'b0, 2'd2, 32'hbfc0_0100, 32'd0, 32'h1000_0000 + k));
      else sb.push_back(mk(1'b1, 1'b0, 2'd1, 32'h8000_2000, 32'h0bad_cafe, 32'h1000_0000 + k));
      serve(0, 1, 32'h1000_0000 + k, 1'b0, 1'b0, o);
      e = sb.pop_front();
      n_cmp++;
      if (o.txn !== e || o.lat !== 1) begin
        n_bad++;
        $display("FAIL starve_txn%0d: got %h lat %0d want %h lat 1", k, o.txn, o.lat, e);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_backpressure();
    obs_t o;
    txn_t e;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'h8000_3003; d_wdata = 32'h1122_3344;
    sb.push_back(mk(1'b1, 1'b0, 2'd0, 32'h8000_3003, 32'h1122_3344, 32'h0000_00ab));
    serve(10, 1, 32'h0000_00ab, 1'b1, 1'b0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.unstable !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_stable: got unstable=%b want 0", o.unstable);
    end
    n_cmp++;
    if (o.extra !== 0) begin
      n_bad++;
      $display("FAIL bp_no_early_ok: got %0d pulses want 0", o.extra);
    end
    n_cmp++;
    if (o.txn !== e) begin
      n_bad++;
      $display("FAIL bp_txn: got %h want %h", o.txn, e);
    end
  endtask

  task automatic test_spurious();
    obs_t o;
    txn_t e;
    m_data_ok = 1'b1; m_addr_ok = 1'b1;
    #1;
    n_cmp++;
    if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0000) begin
      n_bad++;
      $display("FAIL spur_idle_ok: got %b want 0000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok});
    end
    @(posedge clk); #1;
    m_data_ok = 1'b0; m_addr_ok = 1'b0;
    #1;
    n_cmp++;
    if (m_req !== 1'b0) begin
      n_bad++;
      $display("FAIL spur_idle_state: m_req got %b want 0", m_req);
    end
    i_req = 1'b1; i_wr = 1'b1; i_size = 2'd2; i_addr = 32'hbfc0_0200; i_wdata = 32'hcafe_f00d;
    sb.push_back(mk(1'b0, 1'b1, 2'd2, 32'hbfc0_0200, 32'hcafe_f00d, 32'h7777_0000));
    serve(1, 3, 32'h7777_0000, 1'b1, 1'b1, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.extra !== 0) begin
      n_bad++;
      $display("FAIL spur_data_addr_ok: got %0d pulses want 0", o.extra);
    end
    n_cmp++;
    if (o.txn !== e) begin
      n_bad++;
      $display("FAIL spur_txn: got %h want %h", o.txn, e);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    txn_t e;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h8000_4000; d_wdata = 32'd0;
    @(posedge clk); #2;
    n_cmp++;
    if (m_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_addr: m_req got %b want 1", m_req);
    end
    m_addr_ok = 1'b1;
    @(posedge clk); #1;
    m_addr_ok = 1'b0; d_req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_data_ok = 1'b1; m_rdata = 32'h5555_aaaa;
    #1;
    n_cmp++;
    if ({i_data_ok, d_data_ok, m_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_late_data_ok: got %b want 000", {i_data_ok, d_data_ok, m_req});
    end
    @(posedge clk); #1;
    m_data_ok = 1'b0;
    #1;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_4004; d_wdata = 32'h1234_5678;
    sb.push_back(mk(1'b1, 1'b1, 2'd2, 32'h8000_4004, 32'h1234_5678, 32'h0));
    serve(1, 1, 32'h0, 1'b1, 1'b0, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.txn !== e || o.lat !== 1) begin
      n_bad++;
      $display("FAIL rstmid_next_txn: got %h lat %0d want %h lat 1", o.txn, o.lat, e);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_data_priority();
    test_starvation();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
